gen_dpram_be: RTL

- Parametrised true dual-port synchronous RAM; generational successor to the single-port generic RAM used across the sim/arcade video and CPU memory maps.
- Adds per-lane byte enables, selectable read-during-write mode, optional output register stage and a hardware clear engine.
- Lets vector/shadow RAMs be wiped between frames without CPU loops.
- Sits between CPU/video bus decoders and storage; one clock domain.

---
 rtl/gen_dpram_be.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/gen_dpram_be.sv
// True dual-port synchronous RAM with per-lane byte enables, selectable
// read-during-write behaviour, optional output register and a hardware clear engine.
module gen_dpram_be #(
   parameter int                dWidth   = 8,
   parameter int                aWidth   = 10,
   parameter int                bWidth   = 8,
   parameter int                RDW_MODE = 0,
   parameter int                OUT_REG  = 0,
   parameter logic [dWidth-1:0] CLR_VAL  = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clr,
   output logic                       busy,
   input  logic                       cs_a,
   input  logic                       we_a,
   input  logic [dWidth/bWidth-1:0]   be_a,
   input  logic [aWidth-1:0]          addr_a,
   input  logic [dWidth-1:0]          d_a,
   output logic [dWidth-1:0]          q_a,
   input  logic                       cs_b,
   input  logic                       we_b,
   input  logic [dWidth/bWidth-1:0]   be_b,
   input  logic [aWidth-1:0]          addr_b,
   input  logic [dWidth-1:0]          d_b,
   output logic [dWidth-1:0]          q_b
);

   localparam int NB    = dWidth / bWidth;
   localparam int DEPTH = 2 ** aWidth;

   generate
      if (dWidth % bWidth != 0) begin : g_bad_width
         $error("gen_dpram_be: dWidth must be a multiple of bWidth");
      end
   endgenerate

   typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

   state_e              state_q, state_d;
   logic [aWidth-1:0]   cnt_q, cnt_d;

   logic [dWidth-1:0]   mem [DEPTH];
   logic [dWidth-1:0]   old_a, old_b, mrg_a, mrg_b;
   logic                acc_a, acc_b, wr_a, wr_b;
   logic [dWidth-1:0]   rd_a_q, rd_b_q;

   assign busy  = (state_q == ST_CLEAR);
   assign acc_a = cs_a & ~busy;
   assign acc_b = cs_b & ~busy;
   assign wr_a  = acc_a & we_a;
   assign wr_b  = acc_b & we_b;

   // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (clr) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {aWidth{1'b1}}) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Pre-write words and each port's own merged word for read-during-write.
   always_comb begin
      old_a = mem[addr_a];
      old_b = mem[addr_b];
      mrg_a = old_a;
      mrg_b = old_b;
      for (int i = 0; i < NB; i++) begin
         if (be_a[i]) mrg_a[i*bWidth +: bWidth] = d_a[i*bWidth +: bWidth];
         if (be_b[i]) mrg_b[i*bWidth +: bWidth] = d_b[i*bWidth +: bWidth];
      end
   end

   // NOTE: the storage array has no reset; only control and output registers are cleared, the array keeps its contents.
   // Port A lanes are written after port B so A wins on lanes both enable.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (busy) begin
            mem[cnt_q] <= CLR_VAL;
         end else begin
            for (int i = 0; i < NB; i++)
               if (wr_b && be_b[i]) mem[addr_b][i*bWidth +: bWidth] <= d_b[i*bWidth +: bWidth];
            for (int i = 0; i < NB; i++)
               if (wr_a && be_a[i]) mem[addr_a][i*bWidth +: bWidth] <= d_a[i*bWidth +: bWidth];
         end
      end
   end

   // A reader never sees the other port's write in the same cycle: it gets old_x.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_a_q <= '0;
         rd_b_q <= '0;
      end else begin
         if (acc_a) rd_a_q <= (wr_a && RDW_MODE == 0) ? mrg_a : old_a;
         if (acc_b) rd_b_q <= (wr_b && RDW_MODE == 0) ? mrg_b : old_b;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [dWidth-1:0] out_a_q, out_b_q;
         always_ff @(posedge clk) begin
            if (reset) begin
               out_a_q <= '0;
               out_b_q <= '0;
            end else begin
               out_a_q <= rd_a_q;
               out_b_q <= rd_b_q;
            end
         end
         assign q_a = out_a_q;
         assign q_b = out_b_q;
      end else begin : g_no_out_reg
         assign q_a = rd_a_q;
         assign q_b = rd_b_q;
      end
   endgenerate

endmodule
